// File: rtl/my_pkg.sv
// Shared width, operation encoding and the bitwise operation used by logic_op_fifo.
package my_pkg;

  parameter int unsigned N = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_t;

  function automatic logic [N-1:0] apply_op(op_t op, logic [N-1:0] a, logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with valid/ready on both sides; storage is cleared on reset.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  // Handshake flags come only from registered occupancy, so there is no full-bypass path.
  assign push_ready = (level_q != LW'(DEPTH));
  assign pop_valid  = (level_q != '0);
  assign pop_data   = mem_q[rd_ptr_q];
  assign level      = level_q;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/logic_op_fifo.sv
// Selectable bitwise operation on two operands, results buffered in a small FIFO.
module logic_op_fifo
  import my_pkg::*;
#(
  parameter int unsigned N     = my_pkg::N,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               a,
  input  logic [N-1:0]               b,
  input  op_t                        op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               c,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  logic [N-1:0] result;

  always_comb begin
    result = apply_op(op, a, b);
  end

  sync_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (result),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (c),
    .level      (level)
  );

endmodule
